// File: rtl/dcsk_frame_modulator.sv
// dcsk_frame_modulator: DCSK transmit modulator sending SF reference chaos chips, then SF data chips (reference XNOR message bit)
// Ports: i_clk/i_arst clock and async active-high reset; i_sf_log2 spreading factor log2 (1..MAX_SF_LOG2),
// sampled at message accept; i_msg_bit/i_msg_valid/o_msg_ready message handshake; i_chaos_bit/o_chaos_rd chaos chip pull;
// o_chip/o_chip_valid serial chip stream; o_frame_half 0=reference 1=data; o_frame_start first reference chip;
// o_sf_err pulse after a handshake with an illegal SF.
// Optional macro DCSK_FRAME_CNT_EN adds o_frame_cnt (frames started, 16-bit wrapping) and o_busy (not idle).
module dcsk_frame_modulator #(
  parameter int MAX_SF_LOG2 = 4,
  localparam int SF_W = $clog2(MAX_SF_LOG2 + 1)
) (
  input  logic            i_clk,
  input  logic            i_arst,
  input  logic [SF_W-1:0] i_sf_log2,
  input  logic            i_msg_bit,
  input  logic            i_msg_valid,
  output logic            o_msg_ready,
  input  logic            i_chaos_bit,
  output logic            o_chaos_rd,
  output logic            o_chip,
  output logic            o_chip_valid,
  output logic            o_frame_half,
  output logic            o_frame_start,
`ifdef DCSK_FRAME_CNT_EN
  output logic [15:0]     o_frame_cnt,
  output logic            o_busy,
`endif
  output logic            o_sf_err
);
  localparam int W = MAX_SF_LOG2;
  typedef enum logic [1:0] {IDLE, REF, DATA} state_t;
  state_t state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d, sf_m1_q, sf_m1_d;
  logic [2**W-1:0] dly_q, dly_d;
  logic msg_q, msg_d, err_q;
  logic legal, last, ready, accept;
`ifdef DCSK_FRAME_CNT_EN
  logic [15:0] fcnt_q;
`endif
  assign legal = (i_sf_log2 != '0) && (i_sf_log2 <= SF_W'(MAX_SF_LOG2));
  assign last = cnt_q == sf_m1_q;
  assign ready = state_q == IDLE || (state_q == DATA && last);
  assign accept = i_msg_valid && ready && legal;
  always_comb begin
    state_d = state_q;
    cnt_d = state_q == IDLE ? cnt_q : (last ? '0 : cnt_q + W'(1));
    sf_m1_d = sf_m1_q;
    msg_d = msg_q;
    dly_d = dly_q;
    if (state_q == REF) dly_d[cnt_q] = i_chaos_bit;
    if (last) state_d = state_q == REF ? DATA : (state_q == DATA ? IDLE : state_q);
    if (accept) begin
      state_d = REF;
      cnt_d = '0;
      // SF-1 as an all-ones mask of i_sf_log2 bits
      sf_m1_d = ~({W{1'b1}} << i_sf_log2);
      msg_d = i_msg_bit;
    end
  end
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sf_m1_q <= '0;
      msg_q <= 1'b0;
      dly_q <= '0;
      err_q <= 1'b0;
`ifdef DCSK_FRAME_CNT_EN
      fcnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sf_m1_q <= sf_m1_d;
      msg_q <= msg_d;
      dly_q <= dly_d;
      err_q <= i_msg_valid && ready && !legal;
`ifdef DCSK_FRAME_CNT_EN
      if (o_frame_start) fcnt_q <= fcnt_q + 16'd1;
`endif
    end
  end
  assign o_msg_ready = ready;
  assign o_chip_valid = state_q != IDLE;
  assign o_frame_half = state_q == DATA;
  assign o_chaos_rd = state_q == REF;
  assign o_frame_start = state_q == REF && cnt_q == '0;
  assign o_chip = state_q == REF ? i_chaos_bit : (state_q == DATA ? ~(dly_q[cnt_q] ^ msg_q) : 1'b0);
  assign o_sf_err = err_q;
`ifdef DCSK_FRAME_CNT_EN
  assign o_frame_cnt = fcnt_q;
  assign o_busy = state_q != IDLE;
`endif
endmodule

// File: tb/tb_dcsk_frame_modulator.sv
// tb_dcsk_frame_modulator: scoreboard bench for the DCSK frame modulator
module tb_dcsk_frame_modulator;
  logic clk = 1'b0;
  logic arst = 1'b1;
  logic [2:0] sf_log2 = 3'd1;
  logic msg_bit = 1'b0;
  logic msg_valid = 1'b0;
  logic msg_ready, chaos_bit, chaos_rd, chip, chip_valid, frame_half, frame_start, sf_err;
`ifdef DCSK_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  logic busy;
`endif
  logic [255:0] chaos_pat = '0;
  logic [7:0] cidx;
  logic [7:0] exp_idx = 8'd0;
  logic [4:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  dcsk_frame_modulator #(.MAX_SF_LOG2(4)) dut (
    .i_clk(clk),
    .i_arst(arst),
    .i_sf_log2(sf_log2),
    .i_msg_bit(msg_bit),
    .i_msg_valid(msg_valid),
    .o_msg_ready(msg_ready),
    .i_chaos_bit(chaos_bit),
    .o_chaos_rd(chaos_rd),
    .o_chip(chip),
    .o_chip_valid(chip_valid),
    .o_frame_half(frame_half),
    .o_frame_start(frame_start),
`ifdef DCSK_FRAME_CNT_EN
    .o_frame_cnt(frame_cnt),
    .o_busy(busy),
`endif
    .o_sf_err(sf_err)
  );
  always #5 clk = ~clk;
  assign chaos_bit = chaos_pat[cidx];
  always @(posedge clk or posedge arst) begin
    if (arst) cidx <= 8'd0;
    else if (chaos_rd) cidx <= cidx + 8'd1;
  end
  always @(negedge clk) begin
    logic [4:0] e;
    if (chip_valid) begin
      checks++;
      if (exp_q.size() == 0) $display("FAIL sb_unexpected_chip got chip=%b with empty queue", chip);
      else begin
        e = exp_q.pop_front();
        if ({chip, frame_half, frame_start, chaos_rd, msg_ready} !== e)
          $display("FAIL sb_chip got {chip,half,start,rd,ready}=%b want=%b at %0t", {chip, frame_half, frame_start, chaos_rd, msg_ready}, e, $time);
        else passes++;
      end
    end else begin
      checks++;
      if ({chip, frame_half, frame_start, chaos_rd, msg_ready} !== 5'b00001)
        $display("FAIL sb_idle got {chip,half,start,rd,ready}=%b want=00001 at %0t", {chip, frame_half, frame_start, chaos_rd, msg_ready}, $time);
      else passes++;
    end
  end
  task automatic push_frame(input int s, input logic m, input logic [15:0] r);
    int sf = 1 << s;
    for (int k = 0; k < sf; k++) begin
      chaos_pat[8'(exp_idx + k)] = r[sf-1-k];
      exp_q.push_back({r[sf-1-k], 1'b0, k == 0, 1'b1, 1'b0});
    end
    for (int k = 0; k < sf; k++) exp_q.push_back({m ? r[sf-1-k] : ~r[sf-1-k], 1'b1, 1'b0, 1'b0, k == sf - 1});
    exp_idx = 8'(exp_idx + sf);
  endtask
  task automatic send(input logic [2:0] s, input logic m, input logic [15:0] r);
    int g = 0;
    sf_log2 = s;
    msg_bit = m;
    msg_valid = 1'b1;
    @(negedge clk);
    while (!msg_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (!msg_ready) $display("FAIL send_ready got=%b want=1", msg_ready);
    else begin
      passes++;
      push_frame(int'(s), m, r);
    end
    @(posedge clk);
    #1 msg_valid = 1'b0;
  endtask
  task automatic wait_idle;
    int g = 0;
    @(negedge clk);
    while (chip_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (chip_valid) $display("FAIL wait_idle got chip_valid=%b want=0", chip_valid);
    else passes++;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    #1;
    checks++;
    if ({msg_ready, chaos_rd, chip, chip_valid, frame_half, frame_start, sf_err} !== 7'b1000000)
      $display("FAIL reset_initial got=%b want=1000000", {msg_ready, chaos_rd, chip, chip_valid, frame_half, frame_start, sf_err});
    else passes++;
    repeat (3) @(posedge clk);
    #1 arst = 1'b0;
    send(3'd3, 1'($urandom), 16'($urandom));
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (chip_valid !== 1'b1) $display("FAIL reset_midframe_active got chip_valid=%b want=1", chip_valid);
    else passes++;
    arst = 1'b1;
    exp_q.delete();
    exp_idx = 8'd0;
    #1;
    checks++;
    if ({msg_ready, chaos_rd, chip, chip_valid, frame_half, frame_start, sf_err} !== 7'b1000000)
      $display("FAIL reset_async got=%b want=1000000", {msg_ready, chaos_rd, chip, chip_valid, frame_half, frame_start, sf_err});
    else passes++;
    repeat (3) @(posedge clk);
    #1 arst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({msg_ready, chaos_rd, chip_valid} !== 3'b100) $display("FAIL reset_release got=%b want=100", {msg_ready, chaos_rd, chip_valid});
    else passes++;
  endtask
  task automatic test_sf2;
    logic [3:0] want = 4'b1010;
    logic [3:0] half = 4'b0011;
    send(3'd1, 1'b1, 16'h0002);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({chip_valid, chip, frame_half, frame_start, chaos_rd} !== {1'b1, want[3-k], half[3-k], k == 0, k < 2})
        $display("FAIL sf2_chip%0d got {v,chip,half,start,rd}=%b want=%b", k, {chip_valid, chip, frame_half, frame_start, chaos_rd}, {1'b1, want[3-k], half[3-k], k == 0, k < 2});
      else passes++;
    end
    @(negedge clk);
    checks++;
    if (chip_valid !== 1'b0) $display("FAIL sf2_idle got chip_valid=%b want=0", chip_valid);
    else passes++;
    @(posedge clk);
    #1;
  endtask
  task automatic test_sf16;
    logic [31:0] got = '0;
    int nv = 0;
    send(3'd4, 1'b0, 16'hA5C3);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      got = {got[30:0], chip};
      if (chip_valid) nv++;
    end
    checks++;
    if (got !== 32'hA5C3_5A3C || nv != 32) $display("FAIL sf16_frame got=%h valid=%0d want=a5c35a3c valid=32", got, nv);
    else passes++;
    @(negedge clk);
    checks++;
    if (chip_valid !== 1'b0) $display("FAIL sf16_idle got chip_valid=%b want=0", chip_valid);
    else passes++;
    @(posedge clk);
    #1;
  endtask
  task automatic test_back_to_back;
    logic [2:0] bits = 3'b101;
    int acc = 0;
    int nv = 0;
    int first = -1;
    int lastv = -1;
    int nready = 0;
    sf_log2 = 3'd2;
    msg_bit = bits[2];
    msg_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (chip_valid) begin
        nv++;
        if (first < 0) first = i;
        lastv = i;
        if (msg_ready) nready++;
      end
      if (msg_ready && msg_valid && acc < 3) begin
        push_frame(2, bits[2-acc], 16'($urandom));
        acc++;
      end
      @(posedge clk);
      #1;
      if (acc < 3) msg_bit = bits[2-acc];
      else msg_valid = 1'b0;
    end
    checks++;
    if (acc != 3 || nv != 24 || first != 1 || lastv != 24)
      $display("FAIL b2b_stream got accepts=%0d valid=%0d first=%0d last=%0d want 3/24/1/24", acc, nv, first, lastv);
    else passes++;
    checks++;
    if (nready != 3) $display("FAIL b2b_ready got=%0d want=3", nready);
    else passes++;
  endtask
  task automatic test_illegal;
    logic [2:0] bad [2] = '{3'd0, 3'd5};
    int nv = 0;
    for (int i = 0; i < 2; i++) begin
      sf_log2 = bad[i];
      msg_valid = 1'b1;
      @(posedge clk);
      #1 msg_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({sf_err, chip_valid, msg_ready} !== 3'b101) $display("FAIL illegal_sf%0d got {err,v,ready}=%b want=101", bad[i], {sf_err, chip_valid, msg_ready});
      else passes++;
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if ({sf_err, chip_valid} !== 2'b00) $display("FAIL illegal_sf%0d_after got {err,v}=%b want=00", bad[i], {sf_err, chip_valid});
      else passes++;
      @(posedge clk);
      #1;
    end
    send(3'd1, 1'b0, 16'($urandom));
    sf_log2 = 3'd4;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (chip_valid) nv++;
    end
    checks++;
    if (nv != 4) $display("FAIL sf_change_midframe got valid=%0d want=4", nv);
    else passes++;
    @(posedge clk);
    #1;
  endtask
`ifdef DCSK_FRAME_CNT_EN
  task automatic test_frame_cnt;
    logic [15:0] c0 = frame_cnt;
    logic b_last = 1'b0;
    int g = 0;
    send(3'd1, 1'b1, 16'($urandom));
    wait_idle;
    send(3'd2, 1'b0, 16'($urandom));
    wait_idle;
    send(3'd1, 1'b0, 16'($urandom));
    @(negedge clk);
    while (chip_valid && g < 50) begin
      b_last = busy;
      @(negedge clk);
      g++;
    end
    checks++;
    if ({b_last, busy} !== 2'b10) $display("FAIL busy_edge got {last_chip,after}=%b want=10", {b_last, busy});
    else passes++;
    checks++;
    if (frame_cnt !== 16'(c0 + 16'd3)) $display("FAIL frame_cnt got=%0d want=%0d", frame_cnt, 16'(c0 + 16'd3));
    else passes++;
    @(posedge clk);
    #1;
  endtask
`endif
  initial begin
    test_reset;
    test_sf2;
    test_sf16;
    test_back_to_back;
    test_illegal;
`ifdef DCSK_FRAME_CNT_EN
    test_frame_cnt;
`endif
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) $display("FAIL sb_drain got=%0d pending want=0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
